scan_display_mux: RTL and testbench

- Parametrised successor to the 4-digit display multiplexer. Time-multiplexes NDIG hex digits onto one shared digit bus and an active-low anode vector.
- Adds frame-synchronous input snapshotting, per-digit blanking, decimal points and PWM brightness.
- Sits between game/score logic and the 7-segment decoder feeding the board display.

---
 rtl/scan_display_mux.sv | 146 ++++++++++++++
 tb/tb_scan_display_mux.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_display_mux.sv
// scan_display_mux
//   Time-multiplexes NDIG hex digits onto a shared nibble bus and an
//   active-low anode vector. Inputs are snapshotted once per frame into
//   shadow registers. Per-digit blanking, decimal points and PWM brightness
//   are supported.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     When it is defined, leading-zero digits (never digit 0) are blanked.
//     The mask is captured together with the shadow registers.
//
// Parameters
//   NDIG      number of digits scanned (>= 2, any value)
//   DWELL_W   dwell counter width; each digit is selected for 2^DWELL_W clocks
//   BRIGHT_W  brightness width (<= DWELL_W)
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   data_in     packed nibbles, digit i = data_in[4i+3:4i], digit 0 rightmost
//   dp_in       per-digit decimal point request, 1 = lit
//   blank_in    per-digit blank, 1 = anode held off
//   bright      PWM duty level, 0 = dark
//   digit       nibble of the selected digit
//   anode       active-low digit enables, at most one bit low
//   dp_n        active-low decimal point of the selected digit
//   frame_tick  one-clock pulse after each shadow load
module scan_display_mux #(
    parameter int NDIG     = 4,
    parameter int DWELL_W  = 18,
    parameter int BRIGHT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*NDIG-1:0]   data_in,
    input  logic [NDIG-1:0]     dp_in,
    input  logic [NDIG-1:0]     blank_in,
    input  logic [BRIGHT_W-1:0] bright,
    output logic [3:0]          digit,
    output logic [NDIG-1:0]     anode,
    output logic                dp_n,
    output logic                frame_tick
);

    localparam int IDX_W = $clog2(NDIG);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                load_pending_q;
    logic [4*NDIG-1:0]   sh_data_q;
    logic [NDIG-1:0]     sh_dp_q;
    logic [NDIG-1:0]     sh_blank_q;
    logic [BRIGHT_W-1:0] sh_bright_q;

    logic [3:0]          digit_q, digit_d;
    logic [NDIG-1:0]     anode_q, anode_d;
    logic                dp_n_q, dp_n_d;
    logic                frame_tick_q;

    logic                dwell_wrap;
    logic                load;
    logic                lit;
    logic                en;
    logic [NDIG-1:0]     eff_blank;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NDIG-1:0]     lz_q, lz_d;

    // Walk from the most significant digit down; a digit is masked while
    // it and everything above it are zero. Digit 0 always stays visible.
    always_comb begin
        logic run;
        lz_d = '0;
        run  = 1'b1;
        for (int unsigned k = NDIG - 1; k >= 1; k--) begin
            run     = run & (data_in[4*k +: 4] == 4'h0);
            lz_d[k] = run;
        end
    end
`endif

    always_comb begin
        dwell_wrap = &dwell_q;
        // Shadow load on the frame-boundary edge or the first edge after reset
        load       = (dwell_wrap && (idx_q == IDX_LAST)) || load_pending_q;
        dwell_d    = dwell_q + 1'b1;
        idx_d      = idx_q;
        if (dwell_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

`ifdef LEADING_ZERO_BLANK_EN
        eff_blank = sh_blank_q | lz_q;
`else
        eff_blank = sh_blank_q;
`endif

        lit     = dwell_q[DWELL_W-1 -: BRIGHT_W] < sh_bright_q;
        en      = lit && !eff_blank[idx_q];
        digit_d = sh_data_q[4*int'(idx_q) +: 4];
        anode_d = en ? ~(NDIG'(1) << idx_q) : '1;
        dp_n_d  = en ? ~sh_dp_q[idx_q] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q        <= '0;
            idx_q          <= '0;
            load_pending_q <= 1'b1;
            sh_data_q      <= '0;
            sh_dp_q        <= '0;
            sh_blank_q     <= '0;
            sh_bright_q    <= '0;
`ifdef LEADING_ZERO_BLANK_EN
            lz_q           <= '0;
`endif
            digit_q        <= '0;
            anode_q        <= '1;
            dp_n_q         <= 1'b1;
            frame_tick_q   <= 1'b0;
        end else begin
            dwell_q        <= dwell_d;
            idx_q          <= idx_d;
            load_pending_q <= 1'b0;
            frame_tick_q   <= load;
            if (load) begin
                sh_data_q   <= data_in;
                sh_dp_q     <= dp_in;
                sh_blank_q  <= blank_in;
                sh_bright_q <= bright;
`ifdef LEADING_ZERO_BLANK_EN
                lz_q        <= lz_d;
`endif
            end
            digit_q <= digit_d;
            anode_q <= anode_d;
            dp_n_q  <= dp_n_d;
        end
    end

    assign digit      = digit_q;
    assign anode      = anode_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_scan_display_mux.sv
// Testbench for scan_display_mux: one NDIG=4 and one NDIG=3 instance
// (DWELL_W=2, BRIGHT_W=2) are driven with the same directed stimulus.
module tb_scan_display_mux;

    typedef struct packed {
        logic       ft;
        logic [3:0] an;
        logic [3:0] dg;
        logic       dp;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] data4;
    logic [3:0]  dp4;
    logic [3:0]  blank4;
    logic [1:0]  bright;

    logic [3:0]  digit4, digit3;
    logic [3:0]  anode4;
    logic [2:0]  anode3;
    logic        dp_n4, dp_n3, ft4, ft3;

    int          n_checks = 0;
    int          n_fail   = 0;
    string       phase    = "reset";

    exp_t        q4[$];
    exp_t        q3[$];

    // Reference state: counter position and shadow values per instance
    int          n;
    logic [15:0] sh_data[2];
    logic [3:0]  sh_dp[2];
    logic [3:0]  sh_bl[2];
    logic [3:0]  sh_lz[2];
    logic [1:0]  sh_br[2];

    scan_display_mux #(.NDIG(4), .DWELL_W(2), .BRIGHT_W(2)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data4),
        .dp_in     (dp4),
        .blank_in  (blank4),
        .bright    (bright),
        .digit     (digit4),
        .anode     (anode4),
        .dp_n      (dp_n4),
        .frame_tick(ft4)
    );

    scan_display_mux #(.NDIG(3), .DWELL_W(2), .BRIGHT_W(2)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data4[11:0]),
        .dp_in     (dp4[2:0]),
        .blank_in  (blank4[2:0]),
        .bright    (bright),
        .digit     (digit3),
        .anode     (anode3),
        .dp_n      (dp_n3),
        .frame_tick(ft3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s [%s] t=%0t: got %0h expected %0h", nm, phase, $time, act, exp_v);
        end
    endtask

    function automatic bit is_load(input int nd, input int cnt);
        return (cnt == 0) || ((cnt % (4 * nd)) == (4 * nd - 1));
    endfunction

    function automatic logic [3:0] lz_of(input int nd, input logic [15:0] d);
        logic [3:0] m;
        m = 4'h0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            bit run;
            run = 1'b1;
            for (int k = nd - 1; k >= 1; k--) begin
                run  = run && (d[4*k +: 4] == 4'h0);
                m[k] = run;
            end
        end
`else
        if (nd < 0) m = 4'hF;
`endif
        return m;
    endfunction

    // Expected registered outputs for counter position cnt (4 clocks per digit)
    function automatic exp_t model_out(input int nd, input int cnt, input int i);
        exp_t e;
        int   idx;
        int   dw;
        bit   en;
        idx  = (cnt / 4) % nd;
        dw   = cnt % 4;
        en   = (dw < int'(sh_br[i])) && !sh_bl[i][idx] && !sh_lz[i][idx];
        e.dg = sh_data[i][4*idx +: 4];
        e.an = 4'hF;
        if (en) e.an[idx] = 1'b0;
        e.dp = en ? ~sh_dp[i][idx] : 1'b1;
        e.ft = is_load(nd, cnt);
        return e;
    endfunction

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 2; i++) begin
            sh_data[i] = '0;
            sh_dp[i]   = '0;
            sh_bl[i]   = '0;
            sh_lz[i]   = '0;
            sh_br[i]   = '0;
        end
    endtask

    // Called just after a negedge: queue the expected output of the next
    // edge, update the shadow model if that edge loads, then wait a clock.
    task automatic cycle();
        for (int i = 0; i < 2; i++) begin
            int nd;
            nd = (i == 0) ? 4 : 3;
            if (i == 0) q4.push_back(model_out(nd, n, i));
            else        q3.push_back(model_out(nd, n, i));
            if (is_load(nd, n)) begin
                sh_data[i] = (i == 0) ? data4 : {4'h0, data4[11:0]};
                sh_dp[i]   = (i == 0) ? dp4 : {1'b0, dp4[2:0]};
                sh_bl[i]   = (i == 0) ? blank4 : {1'b0, blank4[2:0]};
                sh_br[i]   = bright;
                sh_lz[i]   = lz_of(nd, sh_data[i]);
            end
        end
        n++;
        @(negedge clk);
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) cycle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " u4 anode"}, {4'h0, anode4}, 8'h0F);
        chk({tag, " u4 digit"}, {4'h0, digit4}, 8'h00);
        chk({tag, " u4 dp_n"},  {7'h0, dp_n4},  8'h01);
        chk({tag, " u4 ftick"}, {7'h0, ft4},    8'h00);
        chk({tag, " u3 anode"}, {5'h0, anode3}, 8'h07);
        chk({tag, " u3 digit"}, {4'h0, digit3}, 8'h00);
        chk({tag, " u3 dp_n"},  {7'h0, dp_n3},  8'h01);
        chk({tag, " u3 ftick"}, {7'h0, ft3},    8'h00);
    endtask

    // Monitor: one expected entry per clock while the scoreboard is fed
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q4.size() != 0) begin
            e = q4.pop_front();
            chk("u4 anode", {4'h0, anode4}, {4'h0, e.an});
            chk("u4 digit", {4'h0, digit4}, {4'h0, e.dg});
            chk("u4 dp_n",  {7'h0, dp_n4},  {7'h0, e.dp});
            chk("u4 ftick", {7'h0, ft4},    {7'h0, e.ft});
        end
        if (q3.size() != 0) begin
            e = q3.pop_front();
            chk("u3 anode", {4'h0, 1'b1, anode3}, {4'h0, e.an});
            chk("u3 digit", {4'h0, digit3},       {4'h0, e.dg});
            chk("u3 dp_n",  {7'h0, dp_n3},        {7'h0, e.dp});
            chk("u3 ftick", {7'h0, ft3},          {7'h0, e.ft});
        end
    end

    initial begin
        rst    = 1'b1;
        data4  = 16'h1234;
        dp4    = 4'h0;
        blank4 = 4'h0;
        bright = 2'd3;
        model_reset();
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        phase = "scan";
        run(20);

        // Counter 20 is digit 1 of the second frame
        phase = "snapshot";
        data4 = 16'hABCD;
        run(28);

        phase = "bright0";
        bright = 2'd0;
        run(64);

        phase = "bright1";
        bright = 2'd1;
        run(32);

        phase = "blank";
        bright = 2'd3;
        blank4 = 4'b0100;
        run(32);

        phase = "dp_blanked";
        dp4 = 4'b0101;
        run(32);

        phase = "dp0";
        dp4    = 4'b0001;
        blank4 = 4'b0000;
        run(32);

        phase = "lz0050";
        dp4   = 4'b0000;
        data4 = 16'h0050;
        run(32);

        phase = "lz0000";
        data4 = 16'h0000;
        run(32);

        phase = "pre_rst";
        data4 = 16'h1234;
        run(20);
        while ((n % 16) != 10) cycle();

        // Output currently shows digit 2 lit; reset between edges
        phase = "rst_mid";
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        chk_reset_outputs("rst_held");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        phase = "after_rst";
        data4 = 16'h0906;
        run(40);

        @(posedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
